// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg: shared FSM state type and default widths for the BRAM burst controller
package bram_ctrl_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
endpackage

// File: rtl/bram_rfifo.sv
// bram_rfifo: first-word-fall-through read-return FIFO with occupancy count
module bram_rfifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clka_mmcm,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign empty = count == '0;
  assign dout = mem[rptr];
  always_ff @(posedge clka_mmcm)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clka_mmcm) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop) rptr <= nxt(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // issue throttling in the controller keeps a full FIFO from ever seeing a push
  assert property (@(posedge clka_mmcm) disable iff (reset) !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/bram_burst_ctrl.sv
// bram_burst_ctrl: burst command engine driving a single-port BRAM for writes and flow-controlled reads
module bram_burst_ctrl import bram_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int RD_LAT = 2,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic              clka_mmcm,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(RFIFO_DEPTH + 1);
  if (RFIFO_DEPTH < RD_LAT + 1) begin : g_depth_check
    $error("RFIFO_DEPTH must be at least RD_LAT+1");
  end
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0] rem;
  logic fin, mem_rd, beat, issue, push, pop, empty;
  logic [RD_LAT-1:0] pipe;
  logic [CW-1:0] count, inflight;
  logic [CW:0] occ;
  bram_rfifo #(.DATA_W(DATA_W), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clka_mmcm(clka_mmcm),
    .reset(reset),
    .push(push),
    .din(mem_dout),
    .pop(pop),
    .dout(rd_data),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    occ = {1'b0, count} + {1'b0, inflight};
    beat = state == WRITE && !fin && wr_valid;
    issue = state == READ && occ < (CW+1)'(RFIFO_DEPTH);
    push = pipe[RD_LAT-1];
    pop = !empty && rd_ready;
  end
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  // fin marks that every write beat is taken; the cycle after carries the final mem_we
  assign wr_ready = state == WRITE && !fin;
  assign rd_valid = !empty;
  assign done = (state == WRITE && fin) || (state == DRAIN && inflight == '0 && empty);
  always_ff @(posedge clka_mmcm) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      fin <= 1'b0;
      mem_we <= 1'b0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      pipe <= '0;
      inflight <= '0;
    end else begin
      mem_we <= beat;
      mem_rd <= issue;
      pipe <= RD_LAT'({pipe, mem_rd});
      inflight <= inflight + CW'(issue) - CW'(push);
      if (beat || issue) begin
        mem_addr <= addr;
        addr <= addr + ADDR_W'(1);
        rem <= rem - LEN_W'(1);
      end
      if (beat) mem_din <= wr_data;
      if (beat && rem == '0) fin <= 1'b1;
      if (issue && rem == '0) state <= DRAIN;
      if (state == IDLE && cmd_valid) begin
        addr <= cmd_addr;
        rem <= cmd_len;
        fin <= 1'b0;
        state <= cmd_write ? WRITE : READ;
      end
      if (done) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bram_burst_ctrl.sv
// tb_bram_burst_ctrl: directed bursts against a queue-based write/read model with a behavioural BRAM
module tb_bram_burst_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LW = 8;
  logic clka_mmcm = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout, r1;
  logic busy, done;
  int checks = 0, failures = 0, cyc = 0, we_cnt = 0, rd_cnt = 0, pop_cyc = -10;
  logic [DW-1:0] last_rd = '0;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ref_mem [1024];
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t wq[$];
  wr_t w;
  logic [DW-1:0] rq[$];

  bram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RD_LAT(2), .RFIFO_DEPTH(4)) dut (
    .clka_mmcm(clka_mmcm), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .done(done)
  );

  always #5 clka_mmcm = ~clka_mmcm;

  // RAM with registered read plus output register: two cycles from address to data
  always @(posedge clka_mmcm) begin
    cyc <= cyc + 1;
    if (mem_we) ram[mem_addr] <= mem_din;
    r1 <= ram[mem_addr];
    mem_dout <= r1;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clka_mmcm) if (!reset) begin
    chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
    if (mem_we) begin
      we_cnt++;
      if (wq.size() == 0) chk("spurious_we", 32'(mem_we), 0);
      else begin
        w = wq.pop_front();
        chk("we_addr", 32'(mem_addr), 32'(w.a));
        chk("we_data", 32'(mem_din), 32'(w.d));
      end
    end
    if (rd_valid && rd_ready) begin
      rd_cnt++;
      last_rd = rd_data;
      pop_cyc = cyc;
      if (rq.size() == 0) chk("spurious_rd", 32'(rd_valid), 0);
      else chk("rd_data", 32'(rd_data), 32'(rq.pop_front()));
    end
  end

  task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clka_mmcm); #1;
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    @(posedge clka_mmcm); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    dc = -1;
    while (n < 400) begin
      @(negedge clka_mmcm);
      if (done) begin
        dc = cyc;
        break;
      end
      n++;
    end
    chk("done_seen", 32'(dc >= 0), 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int l, input logic [DW-1:0] base, input bit tog, input logic [AW-1:0] last_a);
    int beats = 0, n = 0, we0, dc;
    logic acc;
    for (int i = 0; i <= l; i++) begin
      wq.push_back({AW'(a + i), DW'(base + i)});
      ref_mem[AW'(a + i)] = DW'(base + i);
    end
    we0 = we_cnt;
    do_cmd(1'b1, a, LW'(l));
    while (beats <= l && n < 500) begin
      wr_valid = tog ? (n % 2 == 0) : 1'b1;
      wr_data = DW'(base + beats);
      @(negedge clka_mmcm);
      acc = wr_valid && wr_ready;
      @(posedge clka_mmcm); #1;
      if (acc) beats++;
      n++;
    end
    wr_valid = 1'b0;
    chk("wr_beats", beats, l + 1);
    wait_done(dc);
    chk("wr_done_with_we", 32'(mem_we), 1);
    chk("wr_last_addr", 32'(mem_addr), 32'(last_a));
    @(negedge clka_mmcm);
    chk("wr_idle", 32'(cmd_ready), 1);
    chk("wr_done_pulse", 32'(done), 0);
    chk("wr_we_count", we_cnt - we0, l + 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int l, input int hold);
    int r0, dc;
    for (int i = 0; i <= l; i++) rq.push_back(ref_mem[AW'(a + i)]);
    r0 = rd_cnt;
    rd_ready = (hold == 0);
    do_cmd(1'b0, a, LW'(l));
    if (hold > 0) begin
      repeat (hold) @(negedge clka_mmcm);
      chk("stall_issue_addr", 32'(mem_addr), 32'(AW'(a + 3)));
      chk("stall_rd_valid", 32'(rd_valid), 1);
      chk("stall_busy", 32'(busy), 1);
      @(posedge clka_mmcm); #1;
      rd_ready = 1'b1;
    end
    wait_done(dc);
    chk("rd_done_after_pop", dc, pop_cyc + 1);
    chk("rd_count", rd_cnt - r0, l + 1);
    @(negedge clka_mmcm);
    chk("rd_idle", 32'(cmd_ready), 1);
    chk("rd_done_pulse", 32'(done), 0);
  endtask

  initial begin
    int r0, n;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = DW'(16'hC000 ^ i);
      ref_mem[i] = DW'(16'hC000 ^ i);
    end
    repeat (3) @(posedge clka_mmcm);
    @(negedge clka_mmcm);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clka_mmcm); #1;
    reset = 1'b0;

    do_write(10'h010, 3, 16'hA000, 1'b0, 10'h013);
    do_read(10'h010, 3, 0);
    chk("rd_last_lit_a003", 32'(last_rd), 32'h0000A003);
    do_write(10'h3FE, 3, 16'hB000, 1'b0, 10'h001);
    do_read(10'h3FE, 3, 0);
    chk("wrap_rd_last_lit", 32'(last_rd), 32'h0000B003);
    do_read(10'h100, 15, 20);
    chk("stall_rd_last_lit", 32'(last_rd), 32'h0000C10F);
    do_write(10'h200, 3, 16'hD000, 1'b1, 10'h203);
    do_read(10'h200, 3, 0);
    chk("tog_rd_last_lit", 32'(last_rd), 32'h0000D003);
    do_write(10'h300, 0, 16'hE000, 1'b0, 10'h300);
    do_read(10'h300, 0, 0);
    chk("len0_rd_lit", 32'(last_rd), 32'h0000E000);

    for (int i = 0; i < 8; i++) rq.push_back(ref_mem[10'h040 + i]);
    r0 = rd_cnt;
    rd_ready = 1'b1;
    do_cmd(1'b0, 10'h040, 8'd7);
    n = 0;
    while (rd_cnt - r0 < 2 && n < 100) begin
      @(posedge clka_mmcm); #1;
      n++;
    end
    chk("rst_reach_beat2", 32'(rd_cnt - r0 >= 2), 1);
    reset = 1'b1;
    @(posedge clka_mmcm); #1;
    reset = 1'b0;
    rq.delete();
    @(negedge clka_mmcm);
    chk("abort_rd_valid", 32'(rd_valid), 0);
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clka_mmcm);
      chk("abort_quiet", 32'({rd_valid, mem_we}), 0);
    end
    do_read(10'h050, 0, 0);
    chk("post_abort_rd_lit", 32'(last_rd), 32'h0000C050);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
